instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Initiator end of the processor's Run/Done instruction handshake.
//  - Holds a small loadable program RAM.
//  - Issues each 16-bit instruction on DIN with a one-cycle Run pulse, then waits for Done.
//  - After Done, advances the PC and stops after prog_len instructions.
//  - Sits between the board/testbench program loader and proc's DIN/Run/Done ports.
// PARAMETERS
//  ADDR_W     5    program RAM address width; DEPTH = 2**ADDR_W words of 16 bits
//  WD_CYCLES  15   watchdog limit: max WAIT cycles per instruction (only with SEQ_WATCHDOG_EN)
// PORTS
//  Clock     in   1         single clock, rising edge
//  Resetn    in   1         asynchronous, active-low reset
//  Start     in   1         begin execution at address 0 (sampled in IDLE/HALT only)
//  Abort     in   1         stop after the current instruction completes
//  wr_en     in   1         program RAM write strobe
//  wr_addr   in   ADDR_W    program RAM write address
//  wr_data   in   16        program RAM write data
//  prog_len  in   ADDR_W+1  number of instructions to run, 0..DEPTH
//  DIN       out  16        instruction to processor (registered)
//  Run       out  1         issue strobe to processor (registered)
//  Done      in   1         processor instruction-complete (combinational from proc)
//  Busy      out  1         high in ISSUE or WAIT
//  Halted    out  1         high in HALT
//  pc        out  ADDR_W    address of the instruction being or last issued
//  icount    out  ADDR_W+1  instructions completed since last Start
//  Timeout   out  1         watchdog fired (tied 0 without SEQ_WATCHDOG_EN)
// BEHAVIOUR
//  Reset (async, Resetn=0): state=IDLE; DIN=0, Run=0, Busy=0, Halted=0, pc=0, icount=0, Timeout=0.
//    Takes effect immediately, even mid-instruction. The processor is reset separately.
//  States:
//  - IDLE:  Start=1 & Abort=0 -> clear icount/Timeout.
//             Then, if eff_len=0 -> HALT; else pc<=0, DIN<=mem[0], Run<=1 -> ISSUE.
//  - ISSUE: exactly one cycle with Run=1; proc loads IR at this edge. -> WAIT with Run<=0.
//             Done is ignored here.
//  - WAIT:  DIN is held stable. On a sampled Done=1, icount<=icount+1, then:
//             if icount+1 = eff_len or an abort is pending -> HALT;
//             else pc<=pc+1, DIN<=mem[pc+1], Run<=1 -> ISSUE.
//             The next issue is back-to-back, with no bubble.
//  - HALT:  Halted=1; outputs hold. Start behaves exactly as in IDLE (restart).
//  eff_len = min(prog_len, DEPTH). prog_len > DEPTH is clamped, with no wrap of pc.
//  Latency:
//  - Start sampled at edge n -> Run=1 during cycle n+1.
//  - Done sampled at edge m -> next Run=1 during cycle m+1.
//  Abort:
//  - Sampled in ISSUE/WAIT, it sets a pending flag. The machine halts on the next Done.
//    The processor is never left mid-instruction.
//  - Abort in IDLE/HALT blocks Start in the same cycle (Abort wins).
//  RAM writes:
//  - Accepted only in IDLE/HALT; ignored while Busy.
//  - Start together with wr_en to address 0: the write lands, and DIN gets the OLD mem[0].
//  - Reads are synchronous into DIN only.
//  Width rules: icount saturates at DEPTH (cannot exceed eff_len); pc never exceeds DEPTH-1.
// CONFIGURATION
//  SEQ_WATCHDOG_EN defined:
//  - A wait counter clears on entry to WAIT and increments each WAIT cycle without Done.
//  - When it reaches WD_CYCLES: Timeout<=1 -> HALT, icount not incremented.
//  - Timeout stays high until the next accepted Start or reset.
//  SEQ_WATCHDOG_EN undefined:
//  - No counter; WAIT waits forever.
//  - Timeout is constant 0.
// TESTING
//  1. Reset, load mem[0..2]={16'h1205,16'h4401,16'h5E00}, prog_len=3, Start with proc attached
//     -> 3 Run pulses; final Halted=1, icount=3, pc=2.
//  2. Back-to-back: model Done=1 the cycle after ISSUE
//     -> Run high every 2nd cycle; DIN shows 16'h1205,16'h4401,16'h5E00 in order.
//  3. prog_len=0, Start -> HALT next cycle, Run never asserted, icount=0.
//     prog_len=40 with ADDR_W=5 -> exactly 32 issues.
//  4. Abort during WAIT of instr 1 of 3, Done after 2 cycles
//     -> Halted=1, icount=2, no third Run. Then Start -> reruns from pc=0, icount restarts at 0.
//  5. wr_en while Busy to addr 1 with 16'hFFFF -> mem unchanged; instruction 1 still issues 16'h4401.
//     Resetn=0 mid-WAIT -> all outputs 0 immediately.
//  6. SEQ_WATCHDOG_EN, WD_CYCLES=15, Done held 0
//     -> Timeout=1, Halted=1 after 15 WAIT cycles, icount unchanged.
//     Without the macro -> still Busy after 100 cycles.

Source files
------------

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
//   Initiator side of the processor Run/Done instruction handshake. Holds a
//   small loadable program RAM, issues each 16-bit instruction on DIN with a
//   one-cycle Run pulse, waits for Done, then advances until prog_len
//   instructions (clamped to DEPTH) have completed.
//
//   Optional feature macro: SEQ_WATCHDOG_EN
//     defined   -> per-instruction WAIT watchdog of WD_CYCLES cycles drives
//                  Timeout and forces HALT
//     undefined -> WAIT waits forever, Timeout is constant 0
//
// Ports
//   Clock, Resetn      clock (rising edge), asynchronous active-low reset
//   Start, Abort       begin program at address 0 / stop after current instr
//   wr_en/addr/data    program RAM write port (only honoured in IDLE/HALT)
//   prog_len           instruction count, 0..DEPTH (larger values clamp)
//   DIN, Run           registered instruction and issue strobe to processor
//   Done               instruction-complete from processor
//   Busy, Halted       status: ISSUE/WAIT, HALT
//   pc, icount         current/last issued address, completed count
//   Timeout            watchdog fired
// ----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned WD_CYCLES = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Abort,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W:0]   prog_len,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   icount,
  output logic              Timeout
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                abort_pend;
  logic [LEN_W-1:0]    eff_len;
  logic [LEN_W-1:0]    icount_inc;
  logic [ADDR_W-1:0]   pc_inc;
  logic                idle_like;
  logic                start_ok;

  // Clamp the requested length so pc never wraps past the last RAM word.
  assign eff_len    = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
  assign icount_inc = icount + LEN_W'(1);
  assign pc_inc     = pc + ADDR_W'(1);
  assign idle_like  = (state == S_IDLE) || (state == S_HALT);
  // Abort in IDLE/HALT takes precedence over Start.
  assign start_ok   = idle_like && Start && !Abort;

  // Program RAM: writes only while not executing. Same-edge Start reads the
  // old mem[0] because the FSM samples the array before this update lands.
  always_ff @(posedge Clock) begin
    if (idle_like && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WC_W = $clog2(WD_CYCLES + 1);
  logic [WC_W-1:0] wait_cnt;
`else
  assign Timeout = 1'b0;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      DIN        <= '0;
      Run        <= 1'b0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      pc         <= '0;
      icount     <= '0;
      abort_pend <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wait_cnt   <= '0;
      Timeout    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start_ok) begin
            icount     <= '0;
            abort_pend <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            Timeout    <= 1'b0;
`endif
            if (eff_len == '0) begin
              state  <= S_HALT;
              Halted <= 1'b1;
            end else begin
              pc     <= '0;
              DIN    <= mem[0];
              Run    <= 1'b1;
              Busy   <= 1'b1;
              Halted <= 1'b0;
              state  <= S_ISSUE;
            end
          end
        end

        // Processor loads IR on this edge; Done is not looked at here.
        S_ISSUE: begin
          Run   <= 1'b0;
          state <= S_WAIT;
`ifdef SEQ_WATCHDOG_EN
          wait_cnt <= '0;
`endif
          if (Abort) begin
            abort_pend <= 1'b1;
          end
        end

        S_WAIT: begin
          if (Done) begin
            icount <= icount_inc;
            // A same-cycle Abort also counts as pending.
            if ((icount_inc == eff_len) || abort_pend || Abort) begin
              state  <= S_HALT;
              Busy   <= 1'b0;
              Halted <= 1'b1;
            end else begin
              pc    <= pc_inc;
              DIN   <= mem[pc_inc];
              Run   <= 1'b1;
              state <= S_ISSUE;
            end
          end else begin
            if (Abort) begin
              abort_pend <= 1'b1;
            end
`ifdef SEQ_WATCHDOG_EN
            // Counter holds WAIT cycles seen so far without Done.
            if (wait_cnt == WC_W'(WD_CYCLES - 1)) begin
              Timeout <= 1'b1;
              state   <= S_HALT;
              Busy    <= 1'b0;
              Halted  <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WC_W'(1);
            end
`endif
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
